// File: rtl/ats21_alarm_event_queue.sv
// ats21_alarm_event_queue
// Converts rising edges of the ATS21 alarm "finished" vector into timestamped
// events held in a first-word-fall-through queue, popped by the host.
//
// Handshake: an event is popped at a clk edge when ev_valid && ev_ready are
// both high in the cycle before it. ev_valid is high whenever the queue holds
// at least one entry. ev_ready while ev_valid=0 has no effect.
//
// Optional build macro ATS21_EVQ_IRQ_THRESH_EN adds the irq_thresh input and
// holds irq low until the queue fill level reaches the threshold. When it is
// undefined, irq is simply "queue not empty".
module ats21_alarm_event_queue #(
  parameter int NUM_ALARMS = 24,
  parameter int DEPTH      = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_ALARMS-1:0]         alarm_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(NUM_ALARMS)-1:0] ev_id,
  output logic [TS_WIDTH-1:0]           ev_time,
  output logic [$clog2(DEPTH):0]        ev_count,
  output logic                          overflow,
  input  logic                          clear_overflow,
`ifdef ATS21_EVQ_IRQ_THRESH_EN
  input  logic [$clog2(DEPTH):0]        irq_thresh,
`endif
  output logic                          irq
);

  localparam int IDW = $clog2(NUM_ALARMS);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  // Free-running timestamp and edge-detect state
  logic [TS_WIDTH-1:0]   ts_q;
  logic [NUM_ALARMS-1:0] prev_q;
  logic [NUM_ALARMS-1:0] rise;

  // Per-alarm pending bits with the time captured at their first rise
  logic [NUM_ALARMS-1:0] pending_q, pending_d;
  logic [NUM_ALARMS-1:0] push_mask, pend_after_push, cap_en;
  logic [TS_WIDTH-1:0]   cap_time_q [NUM_ALARMS];

  // Queue storage and bookkeeping
  logic [IDW-1:0]        mem_id_q   [DEPTH];
  logic [TS_WIDTH-1:0]   mem_time_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;

  logic                  overflow_q, overflow_d;
  logic                  irq_q, irq_d;

  logic                  any_pending;
  logic                  push, pop;
  logic [IDW-1:0]        sel_idx;

  assign rise = alarm_data & ~prev_q;

  // Lowest-index pending alarm wins the single push slot each cycle
  always_comb begin
    sel_idx     = '0;
    any_pending = |pending_q;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = IDW'(i);
    end
  end

  assign pop  = (count_q != '0) && ev_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push = any_pending && ((count_q != CW'(DEPTH)) || pop);

  // Pending update: a bit being pushed this cycle counts as free, so a fresh
  // rise on it re-arms it with a new capture time instead of coalescing.
  always_comb begin
    push_mask       = '0;
    if (push) push_mask = NUM_ALARMS'(1) << sel_idx;
    pend_after_push = pending_q & ~push_mask;
    cap_en          = rise & ~pend_after_push;
    pending_d       = pend_after_push | rise;
  end

  // Sticky overflow: a coalesced rise outranks a simultaneous clear
  always_comb begin
    overflow_d = overflow_q;
    if (clear_overflow) overflow_d = 1'b0;
    if (|(rise & pend_after_push)) overflow_d = 1'b1;
  end

  // Fill level and interrupt computed from the post-edge fill level
  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
`ifdef ATS21_EVQ_IRQ_THRESH_EN
    irq_d = (count_d != '0) &&
            (count_d >= ((irq_thresh == '0) ? CW'(1) : irq_thresh));
`else
    irq_d = (count_d != '0);
`endif
  end

  // Control state: timestamp, edge detect, pending, pointers, flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q       <= '0;
      prev_q     <= '0;
      pending_q  <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) cap_time_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ts_q      <= ts_q + TS_WIDTH'(1);
      prev_q    <= alarm_data;
      pending_q <= pending_d;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (cap_en[i]) cap_time_q[i] <= ts_q;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  // Queue payload storage; contents are only meaningful behind count_q
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id_q[wr_ptr_q]   <= sel_idx;
      mem_time_q[wr_ptr_q] <= cap_time_q[sel_idx];
    end
  end

  assign ev_valid = (count_q != '0);
  assign ev_id    = ev_valid ? mem_id_q[rd_ptr_q]   : '0;
  assign ev_time  = ev_valid ? mem_time_q[rd_ptr_q] : '0;
  assign ev_count = count_q;
  assign overflow = overflow_q;
  assign irq      = irq_q;

endmodule
